// File: rtl/piano_pkg.sv
// Shared piano definitions: recorder state encoding and note/playback constants.
package piano_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    REC,
    DONE
  } rec_state_t;

  localparam int NOTE_W = 8;
  localparam logic [7:0] PLAY_LAST_ADDR = 8'h10;

endpackage

// File: rtl/tick_div.sv
// Sample-rate divider: one-cycle tick every TICK_DIV clocks, restartable via clr.
module tick_div #(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/note_recorder.sv
// Records sampled piano keys into note RAM port B: clears a take area, then
// writes one active-high note pattern per tick until full or stopped.
module note_recorder
  import piano_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int MAX_LEN  = 17,
  parameter int TICK_DIV = 5_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rec_btn,
  input  logic [NOTE_W-1:0] keys,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [NOTE_W-1:0] ram_wdata,
  output logic              recording,
  output logic [ADDR_W:0]   rec_len,
  output logic              take_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_LEN - 1);
  localparam logic [ADDR_W:0]   FULL_LEN  = (ADDR_W + 1)'(MAX_LEN);

  rec_state_t        state;
  logic              rec_s1, rec_s2, rec_d, rec_press;
  logic [NOTE_W-1:0] keys_s1, keys_s2;
  logic [ADDR_W:0]   count;
  logic              stop_pend;
  logic              tick, tick_clr, finish;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_s1    <= 1'b1;
      rec_s2    <= 1'b1;
      rec_d     <= 1'b1;
      rec_press <= 1'b0;
      keys_s1   <= '1;
      keys_s2   <= '1;
    end else begin
      rec_s1    <= rec_btn;
      rec_s2    <= rec_s1;
      rec_d     <= rec_s2;
      rec_press <= rec_d & ~rec_s2;
      keys_s1   <= keys;
      keys_s2   <= keys_s1;
    end
  end

  // Restart the divider on the last CLEAR cycle so REC begins at count 0.
  assign tick_clr = (state == CLEAR) && (ram_addr == LAST_ADDR);

  tick_div #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_div (
    .clk (clk),
    .rst (rst),
    .clr (tick_clr),
    .tick(tick)
  );

  // A stop coinciding with a tick is deferred one cycle so the sample lands first.
  assign finish = stop_pend || (count == FULL_LEN) || (rec_press && !tick);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      recording <= 1'b0;
      rec_len   <= '0;
      take_done <= 1'b0;
      count     <= '0;
      stop_pend <= 1'b0;
    end else begin
      ram_we    <= 1'b0;
      take_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rec_press) begin
            state     <= CLEAR;
            ram_we    <= 1'b1;
            ram_addr  <= '0;
            ram_wdata <= '0;
            recording <= 1'b1;
          end
        end
        CLEAR: begin
          if (ram_addr == LAST_ADDR) begin
            state     <= REC;
            ram_addr  <= '0;
            count     <= '0;
            stop_pend <= 1'b0;
          end else begin
            ram_we   <= 1'b1;
            ram_addr <= ram_addr + 1'b1;
          end
        end
        REC: begin
          if (finish) begin
            state     <= DONE;
            recording <= 1'b0;
            take_done <= 1'b1;
            rec_len   <= count;
            stop_pend <= 1'b0;
          end else if (tick) begin
            ram_we    <= 1'b1;
            ram_addr  <= count[ADDR_W-1:0];
            ram_wdata <= ~keys_s2;
            count     <= count + 1'b1;
            stop_pend <= rec_press;
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_recorder.sv
// Bench for note_recorder: randomized takes checked against a cycle-schedule model.
module tb_note_recorder;

  localparam int ADDR_W   = 8;
  localparam int MAX_LEN  = 17;
  localparam int TICK_DIV = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rec_btn = 1'b1;
  logic [7:0]        keys = 8'hFF;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              recording;
  logic [ADDR_W:0]   rec_len;
  logic              take_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int c;
    int a;
    int d;
  } wr_t;

  wr_t wq[$];
  int  dq[$];

  note_recorder #(
    .ADDR_W  (ADDR_W),
    .MAX_LEN (MAX_LEN),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rec_btn  (rec_btn),
    .keys     (keys),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .recording(recording),
    .rec_len  (rec_len),
    .take_done(take_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (ram_we) wq.push_back('{cyc, int'(ram_addr), int'(ram_wdata)});
      if (take_done) dq.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // stop_kind: 0 = runs to full length, 1 = button stop at cycle r+pe_rel, 2 = reset mid-REC.
  task automatic run_take(input int stop_kind, input int pe_rel, input bit fixed);
    int n, c0, r, pe, samples, done_c, rc, last, np, ne;
    int w[MAX_LEN];
    int p[3];
    logic [7:0] pat[MAX_LEN];
    logic [7:0] glt[MAX_LEN];
    logic [7:0] e;
    bit lo;
    wr_t exp_q[$];

    wq.delete();
    dq.delete();
    n  = cyc;
    c0 = n + 4;              // 2 sync flops + edge register + FSM edge
    r  = c0 + MAX_LEN;
    for (int k = 0; k < MAX_LEN; k++) begin
      w[k]   = r + TICK_DIV * (k + 1);
      pat[k] = fixed ? 8'hFE : 8'($urandom);
      glt[k] = ~pat[k];
    end
    if (fixed) begin
      pat[0] = 8'hFF; pat[1] = 8'h7E; pat[2] = 8'h00;
      for (int k = 0; k < 3; k++) glt[k] = ~pat[k];
    end

    rc = w[5] + 1;
    if (stop_kind == 1) begin
      pe = r + pe_rel;
      samples = 0;
      for (int k = 0; k < MAX_LEN; k++) if (w[k] <= pe) samples++;
      done_c = (samples > 0 && w[samples-1] == pe) ? pe + 1 : pe;
    end else if (stop_kind == 0) begin
      samples = MAX_LEN;
      done_c = w[MAX_LEN-1] + 1;
    end else begin
      samples = 6;
      done_c = -100;
    end

    p[0] = n;
    p[1] = c0 + 4;           // press lands mid-CLEAR
    np = 2;
    if (stop_kind == 1) begin p[2] = pe - 4; np = 3; end
    if (stop_kind == 0) begin p[2] = done_c - 3; np = 3; end   // press lands in DONE
    last = (stop_kind == 2) ? rc + 8 : done_c + 6;

    for (int c = n; c <= last; c++) begin
      wait_cyc(c);
      if (c == c0 - 1) chk("rec_before_clear", 32'(recording), 32'd0);
      if (c == c0) begin
        chk("rec_in_clear", 32'(recording), 32'd1);
        chk("we_in_clear", 32'(ram_we), 32'd1);
      end
      if (stop_kind != 2) begin
        if (c == done_c - 1) chk("rec_last_rec", 32'(recording), 32'd1);
        if (c == done_c) begin
          chk("rec_in_done", 32'(recording), 32'd0);
          chk("take_done", 32'(take_done), 32'd1);
          chk("rec_len", 32'(rec_len), 32'(samples));
        end
        if (c == done_c + 1) chk("take_done_pulse", 32'(take_done), 32'd0);
      end else begin
        if (c == rc) begin
          chk("addr_before_rst", 32'(ram_addr), 32'd5);
          rst = 1'b1;
          #1;
          chk("rst_we", 32'(ram_we), 32'd0);
          chk("rst_recording", 32'(recording), 32'd0);
          chk("rst_addr", 32'(ram_addr), 32'd0);
          chk("rst_rec_len", 32'(rec_len), 32'd0);
          chk("rst_take_done", 32'(take_done), 32'd0);
        end
        if (c == rc + 2) rst = 1'b0;
        if (c == rc + 7) begin
          chk("idle_recording", 32'(recording), 32'd0);
          chk("idle_addr", 32'(ram_addr), 32'd0);
          chk("idle_rec_len", 32'(rec_len), 32'd0);
        end
      end
      lo = 1'b0;
      for (int j = 0; j < np; j++) if (c >= p[j] && c < p[j] + 2) lo = 1'b1;
      rec_btn = ~lo;
      for (int k = 0; k < MAX_LEN; k++) begin
        if (c == w[k] - 3) keys = pat[k];   // early enough to be sampled
        if (c == w[k] - 2) keys = glt[k];   // too late: must not reach this sample
      end
    end
    rec_btn = 1'b1;

    for (int i = 0; i < MAX_LEN; i++) exp_q.push_back('{c0 + i, i, 0});
    for (int k = 0; k < samples; k++) begin
      e = ~pat[k];
      exp_q.push_back('{w[k], k, int'(e)});
    end
    chk("write_count", 32'(wq.size()), 32'(exp_q.size()));
    ne = (wq.size() < exp_q.size()) ? wq.size() : exp_q.size();
    for (int i = 0; i < ne; i++) begin
      chk($sformatf("wr%0d_cycle", i), 32'(wq[i].c), 32'(exp_q[i].c));
      chk($sformatf("wr%0d_addr", i), 32'(wq[i].a), 32'(exp_q[i].a));
      chk($sformatf("wr%0d_data", i), 32'(wq[i].d), 32'(exp_q[i].d));
    end
    chk("done_count", 32'(dq.size()), (stop_kind == 2) ? 32'd0 : 32'd1);
    if (dq.size() > 0 && stop_kind != 2) chk("done_cycle", 32'(dq[0]), 32'(done_c));
  endtask

  initial begin
    @(negedge clk);
    chk("reset_we", 32'(ram_we), 32'd0);
    chk("reset_addr", 32'(ram_addr), 32'd0);
    chk("reset_wdata", 32'(ram_wdata), 32'd0);
    chk("reset_recording", 32'(recording), 32'd0);
    chk("reset_rec_len", 32'(rec_len), 32'd0);
    chk("reset_take_done", 32'(take_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    run_take(0, 0, 1'b1);                                   // full take, fixed patterns
    run_take(1, 3 * TICK_DIV, 1'b0);                        // stop on the third tick
    run_take(1, int'($urandom_range(1, 4 * MAX_LEN - 1)), 1'b0);
    run_take(0, 0, 1'b0);                                   // full take, random keys
    run_take(2, 0, 1'b0);                                   // reset at address 5

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
